// File: rtl/lvda_ss_pkg.sv
// rtl/lvda_ss_pkg.sv - shared types and constants for the switch-selector register/sequencer
package lvda_ss_pkg;

    localparam int SS_CODE_W         = 5;
    localparam int SETTLE_CYCLES_DEF = 4;
    localparam int READ_CYCLES_DEF   = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ARMED,
        ST_READ,
        ST_CLEAR
    } ss_state_t;

    // Only IDLE and ARMED are resting states; everything else is a timed or transient phase.
    function automatic logic is_busy(input ss_state_t s);
        return !((s == ST_IDLE) || (s == ST_ARMED));
    endfunction

endpackage

// File: rtl/ss_cycle_timer.sv
// rtl/ss_cycle_timer.sv - saturating up-counter with terminal-count compare, shared by SETTLE and READ
module ss_cycle_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Saturates rather than wraps so a stuck enable can never alias back to a small count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == limit);

endmodule

// File: rtl/ss_register_sequencer.sv
// rtl/ss_register_sequencer.sv - switch-selector code register, feedback word and timed read sequencer
module ss_register_sequencer
    import lvda_ss_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int READ_CYCLES   = READ_CYCLES_DEF,
    parameter int CNT_W         = 5
) (
    input  logic                 SIM_CLK,
    input  logic                 SIM_RST,
    input  logic [SS_CODE_W-1:0] SSD,
    input  logic                 SSLD,
    input  logic                 SSRDCMD,
    input  logic                 SSRSTCMD,
    output logic                 SSR9H,
    output logic                 SSR10H,
    output logic                 SSR11H,
    output logic                 SSR12H,
    output logic                 SSR13H,
    output logic [SS_CODE_W-1:0] SSFB,
    output logic                 SSREAD,
    output logic                 SSBUSY,
    output logic                 SSERR
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LAST   = CNT_W'(READ_CYCLES - 1);

    ss_state_t            state;
    ss_state_t            state_n;
    logic [SS_CODE_W-1:0] code;
    logic                 code_ld;
    logic                 code_clr;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic                 cnt_done;
    logic [CNT_W-1:0]     cnt_limit;
    logic                 illegal;
    logic                 err_q;

    assign cnt_limit = (state == ST_READ) ? READ_LAST : SETTLE_LAST;

    ss_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (SIM_CLK),
        .rst_n (SIM_RST),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_limit),
        .done  (cnt_done)
    );

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Counter is held at zero unless a timed state is actively counting, so every entry starts at 0.
    always_comb begin
        state_n  = state;
        code_ld  = 1'b0;
        code_clr = 1'b0;
        cnt_clr  = 1'b1;
        cnt_en   = 1'b0;
        illegal  = 1'b0;
        if (SSRSTCMD) begin
            state_n  = ST_IDLE;
            code_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    illegal = SSRDCMD;
                    if (SSLD) begin
                        code_ld = 1'b1;
                        state_n = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    illegal = SSRDCMD;
                    if (SSLD) begin
                        code_ld = 1'b1;
                    end else if (cnt_done) begin
                        state_n = ST_ARMED;
                    end else begin
                        cnt_clr = 1'b0;
                        cnt_en  = 1'b1;
                    end
                end
                ST_ARMED: begin
                    illegal = SSLD && SSRDCMD;
                    if (SSLD) begin
                        code_ld = 1'b1;
                        state_n = ST_SETTLE;
                    end else if (SSRDCMD) begin
                        state_n = ST_READ;
                    end
                end
                ST_READ: begin
                    illegal = SSLD || SSRDCMD;
                    if (cnt_done) begin
                        code_clr = 1'b1;
                        state_n  = ST_CLEAR;
                    end else begin
                        cnt_clr = 1'b0;
                        cnt_en  = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    illegal  = SSLD || SSRDCMD;
                    code_clr = 1'b1;
                    state_n  = ST_IDLE;
                end
                default: begin
                    state_n  = ST_IDLE;
                    code_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            code <= '0;
        end else if (code_clr) begin
            code <= '0;
        end else if (code_ld) begin
            code <= SSD;
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= illegal;
        end
    end

    assign SSR9H  = code[0];
    assign SSR10H = code[1];
    assign SSR11H = code[2];
    assign SSR12H = code[3];
    assign SSR13H = code[4];
    assign SSFB   = ((state == ST_ARMED) || (state == ST_READ)) ? ~code : '0;
    assign SSREAD = (state == ST_READ);
    assign SSBUSY = is_busy(state);
    assign SSERR  = err_q;

endmodule

// File: tb/tb_ss_register_sequencer.sv
// tb/tb_ss_register_sequencer.sv - scoreboard bench for the switch-selector register/sequencer
module tb_ss_register_sequencer;

    logic       SIM_CLK;
    logic       SIM_RST;
    logic [4:0] SSD;
    logic       SSLD;
    logic       SSRDCMD;
    logic       SSRSTCMD;
    logic       SSR9H, SSR10H, SSR11H, SSR12H, SSR13H;
    logic [4:0] SSFB;
    logic       SSREAD;
    logic       SSBUSY;
    logic       SSERR;

    int checks = 0;
    int errors = 0;
    int err_expected = 0;
    int err_seen = 0;
    logic [4:0] code_q[$];
    logic [4:0] cur_code;
    logic [4:0] ssr;

    assign ssr = {SSR13H, SSR12H, SSR11H, SSR10H, SSR9H};

    ss_register_sequencer dut (
        .SIM_CLK  (SIM_CLK),
        .SIM_RST  (SIM_RST),
        .SSD      (SSD),
        .SSLD     (SSLD),
        .SSRDCMD  (SSRDCMD),
        .SSRSTCMD (SSRSTCMD),
        .SSR9H    (SSR9H),
        .SSR10H   (SSR10H),
        .SSR11H   (SSR11H),
        .SSR12H   (SSR12H),
        .SSR13H   (SSR13H),
        .SSFB     (SSFB),
        .SSREAD   (SSREAD),
        .SSBUSY   (SSBUSY),
        .SSERR    (SSERR)
    );

    initial SIM_CLK = 1'b0;
    always #5 SIM_CLK = ~SIM_CLK;

    always @(negedge SIM_CLK) begin
        if (SSERR === 1'b1) err_seen++;
    end

    task automatic step;
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic load(input logic [4:0] d);
        SSD = d;
        SSLD = 1'b1;
        code_q.push_back(d);
        step();
        SSLD = 1'b0;
    endtask

    task automatic test_reset;
        SIM_RST = 1'b0;
        SSD = '0; SSLD = 0; SSRDCMD = 0; SSRSTCMD = 0;
        #3;
        checks++;
        if ({ssr, SSFB, SSREAD, SSBUSY, SSERR} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {ssr, SSFB, SSREAD, SSBUSY, SSERR});
        end
        repeat (2) step();
        SIM_RST = 1'b1;
        step();
        checks++;
        if ({ssr, SSFB, SSREAD, SSBUSY, SSERR} !== 13'd0) begin
            errors++;
            $display("FAIL post_reset_idle got %b want 0", {ssr, SSFB, SSREAD, SSBUSY, SSERR});
        end
    endtask

    // Loads a code, checks the one-cycle register latency and the 4-cycle settle window.
    task automatic test_load_settle(input logic [4:0] d);
        logic [4:0] exp;
        load(d);
        exp = code_q.pop_front();
        cur_code = exp;
        checks++;
        if (ssr !== exp) begin
            errors++;
            $display("FAIL load_ssr got %b want %b", ssr, exp);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (SSBUSY !== 1'b1 || SSFB !== 5'd0) begin
                errors++;
                $display("FAIL settle_busy cycle %0d got busy=%b fb=%b want busy=1 fb=0", i, SSBUSY, SSFB);
            end
            step();
        end
        checks++;
        if (SSFB !== ~exp || SSBUSY !== 1'b0 || SSREAD !== 1'b0) begin
            errors++;
            $display("FAIL armed_fb got fb=%b busy=%b read=%b want fb=%b busy=0 read=0", SSFB, SSBUSY, SSREAD, ~exp);
        end
    endtask

    // Issues a read from ARMED; optional illegal SSLD at ld_cycle and reset command at rst_cycle (0 = none).
    task automatic test_read(input int ld_cycle, input int rst_cycle);
        int n;
        logic aborted;
        n = 0;
        aborted = 1'b0;
        SSRDCMD = 1'b1;
        step();
        SSRDCMD = 1'b0;
        while (SSREAD === 1'b1 && n < 40) begin
            n++;
            checks++;
            if (SSFB !== ~cur_code || ssr !== cur_code || SSERR !== (n == ld_cycle + 1 && ld_cycle != 0)) begin
                errors++;
                $display("FAIL read_cycle %0d got fb=%b ssr=%b err=%b want fb=%b ssr=%b", n, SSFB, ssr, SSERR, ~cur_code, cur_code);
            end
            if (n == ld_cycle) begin
                SSD = 5'b00000; SSLD = 1'b1;
                err_expected++;
            end
            if (n == rst_cycle) begin
                SSRSTCMD = 1'b1; SSRDCMD = 1'b1;
                aborted = 1'b1;
            end
            step();
            SSLD = 1'b0; SSRSTCMD = 1'b0; SSRDCMD = 1'b0;
            if (aborted) break;
        end
        if (aborted) begin
            checks++;
            if ({ssr, SSFB, SSREAD, SSBUSY, SSERR} !== 13'd0 || n !== rst_cycle) begin
                errors++;
                $display("FAIL read_abort n=%0d got %b want 0", n, {ssr, SSFB, SSREAD, SSBUSY, SSERR});
            end
        end else begin
            checks++;
            if (n !== 25) begin
                errors++;
                $display("FAIL read_length got %0d want 25", n);
            end
            checks++;
            if (SSREAD !== 1'b0 || SSBUSY !== 1'b1 || ssr !== 5'd0) begin
                errors++;
                $display("FAIL clear_cycle got read=%b busy=%b ssr=%b want 0 1 0", SSREAD, SSBUSY, ssr);
            end
            step();
            checks++;
            if ({ssr, SSFB, SSREAD, SSBUSY} !== 12'd0) begin
                errors++;
                $display("FAIL after_clear got %b want 0", {ssr, SSFB, SSREAD, SSBUSY});
            end
        end
        cur_code = 5'd0;
    endtask

    task automatic test_idle_illegal_read;
        SSRDCMD = 1'b1;
        err_expected++;
        step();
        SSRDCMD = 1'b0;
        checks++;
        if (SSERR !== 1'b1 || SSBUSY !== 1'b0 || SSREAD !== 1'b0) begin
            errors++;
            $display("FAIL idle_read_err got err=%b busy=%b read=%b want 1 0 0", SSERR, SSBUSY, SSREAD);
        end
        step();
        checks++;
        if (SSERR !== 1'b0) begin
            errors++;
            $display("FAIL idle_read_err_width got %b want 0", SSERR);
        end
    endtask

    task automatic test_load_over_read;
        logic [4:0] exp;
        SSD = 5'b11111; SSLD = 1'b1; SSRDCMD = 1'b1;
        code_q.push_back(5'b11111);
        err_expected++;
        step();
        SSLD = 1'b0; SSRDCMD = 1'b0;
        exp = code_q.pop_front();
        cur_code = exp;
        checks++;
        if (ssr !== exp || SSBUSY !== 1'b1 || SSERR !== 1'b1 || SSREAD !== 1'b0 || SSFB !== 5'd0) begin
            errors++;
            $display("FAIL load_over_read got ssr=%b busy=%b err=%b read=%b fb=%b want %b 1 1 0 0", ssr, SSBUSY, SSERR, SSREAD, SSFB, exp);
        end
        repeat (3) step();
        checks++;
        if (SSREAD !== 1'b0 || SSBUSY !== 1'b1) begin
            errors++;
            $display("FAIL load_over_read_settle got read=%b busy=%b want 0 1", SSREAD, SSBUSY);
        end
        step();
        checks++;
        if (SSFB !== ~exp || SSBUSY !== 1'b0) begin
            errors++;
            $display("FAIL load_over_read_armed got fb=%b busy=%b want %b 0", SSFB, SSBUSY, ~exp);
        end
    endtask

    // Reload during SETTLE must restart the 4-cycle window with the new code.
    task automatic test_back_to_back;
        logic [4:0] exp;
        load(5'b01010);
        exp = code_q.pop_front();
        step();
        step();
        test_load_settle(5'b00110);
        checks++;
        if (exp === ssr) begin
            errors++;
            $display("FAIL reload_code got %b want %b", ssr, 5'b00110);
        end
    endtask

    task automatic test_async_reset;
        SSRDCMD = 1'b1;
        step();
        SSRDCMD = 1'b0;
        repeat (4) step();
        #2;
        SIM_RST = 1'b0;
        #1;
        checks++;
        if ({ssr, SSFB, SSREAD, SSBUSY, SSERR} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset got %b want 0", {ssr, SSFB, SSREAD, SSBUSY, SSERR});
        end
        repeat (2) step();
        SIM_RST = 1'b1;
        cur_code = 5'd0;
        test_load_settle(5'b10101);
    endtask

    initial begin
        test_reset();
        test_load_settle(5'b10110);
        test_read(0, 0);
        test_idle_illegal_read();
        test_load_settle(5'b01101);
        test_read(10, 0);
        test_load_settle(5'b11001);
        test_read(0, 7);
        test_load_settle(5'b00001);
        step();
        test_load_settle(5'b00011);
        test_load_over_read();
        test_read(0, 0);
        test_back_to_back();
        test_async_reset();
        step();
        checks++;
        if (err_seen !== err_expected) begin
            errors++;
            $display("FAIL sserr_total got %0d want %0d", err_seen, err_expected);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
